// File: rtl/store_buffer.sv
// In-order store FIFO between the MEM stage and the data_mem write port.
// It also forwards load data from pending stores, or stalls the load when a store only partly covers it.
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  input  logic [DATA_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic [2:0]            st_funct3,
  output logic                  st_ready,
  input  logic                  ld_active,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  input  logic [2:0]            ld_funct3,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  ld_stall,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_funct3,
  output logic                  empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] ent_addr  [DEPTH];
  logic [DATA_WIDTH-1:0] ent_data  [DEPTH];
  logic [2:0]            ent_funct3[DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;

  logic                  enq;
  logic                  hit_s;
  logic                  stall_s;
  logic                  found_s;
  logic [DATA_WIDTH-1:0] fwd_s;
  logic [AW-1:0]         idx_s;
  logic [DATA_WIDTH:0]   s_lo;
  logic [DATA_WIDTH:0]   s_hi;
  logic [DATA_WIDTH:0]   l_lo;
  logic [DATA_WIDTH:0]   l_hi;

  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                   input logic [2:0] f3);
    case (f3)
      3'b000:  extend = {{(DATA_WIDTH-8){d[7]}}, d[7:0]};
      3'b001:  extend = {{(DATA_WIDTH-16){d[15]}}, d[15:0]};
      3'b100:  extend = {{(DATA_WIDTH-8){1'b0}}, d[7:0]};
      3'b101:  extend = {{(DATA_WIDTH-16){1'b0}}, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  assign empty    = (count == {(AW+1){1'b0}});
  assign st_ready = (count != (AW+1)'(DEPTH));
  assign enq      = st_valid && st_ready &&
                    (st_funct3 == 3'b000 || st_funct3 == 3'b001 || st_funct3 == 3'b010);

  // Youngest-first scan of live entries; ranges use one extra bit so the top of memory never wraps to 0.
  always_comb begin
    hit_s   = 1'b0;
    stall_s = 1'b0;
    found_s = 1'b0;
    fwd_s   = {DATA_WIDTH{1'b0}};
    idx_s   = {AW{1'b0}};
    s_lo    = {(DATA_WIDTH+1){1'b0}};
    s_hi    = {(DATA_WIDTH+1){1'b0}};
    l_lo    = {1'b0, ld_addr};
    l_hi    = l_lo + (DATA_WIDTH+1)'(size_of(ld_funct3)) - {{DATA_WIDTH{1'b0}}, 1'b1};
    for (int k = DEPTH - 1; k >= 0; k--) begin
      idx_s = rd_ptr + AW'(k);
      s_lo  = {1'b0, ent_addr[idx_s]};
      s_hi  = s_lo + (DATA_WIDTH+1)'(size_of(ent_funct3[idx_s])) - {{DATA_WIDTH{1'b0}}, 1'b1};
      if (!found_s && ((AW+1)'(k) < count) && (s_lo <= l_hi) && (l_lo <= s_hi)) begin
        found_s = 1'b1;
        if (ent_addr[idx_s] == ld_addr && size_of(ent_funct3[idx_s]) >= size_of(ld_funct3)) begin
          hit_s = 1'b1;
          fwd_s = extend(ent_data[idx_s], ld_funct3);
        end else begin
          stall_s = 1'b1;
        end
      end else begin
        found_s = found_s;
      end
    end
  end

  assign fwd_hit    = ld_active && hit_s;
  assign ld_stall   = ld_active && stall_s;
  assign fwd_data   = fwd_hit ? fwd_s : {DATA_WIDTH{1'b0}};
  // A stalled load yields the port so the blocking store can drain.
  assign mem_wen    = !empty && (!ld_active || ld_stall);
  assign mem_addr   = ent_addr[rd_ptr];
  assign mem_wdata  = ent_data[rd_ptr];
  assign mem_funct3 = ent_funct3[rd_ptr];

  // Entry storage, written at the tail on enqueue.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr]   <= st_addr;
      ent_data[wr_ptr]   <= st_data;
      ent_funct3[wr_ptr] <= st_funct3;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {(AW+1){1'b0}};
    end else begin
      if (enq) wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      if (mem_wen) rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      case ({enq, mem_wen})
        2'b10:   count <= count + {{AW{1'b0}}, 1'b1};
        2'b01:   count <= count - {{AW{1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Randomised bench for store_buffer with a queue-based reference model.
// Directed scenarios add literal expectations that pin the model.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic [2:0]  st_funct3 = 3'b010;
  logic        st_ready;
  logic        ld_active = 1'b0;
  logic [31:0] ld_addr = 32'h0;
  logic [2:0]  ld_funct3 = 3'b010;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic        ld_stall;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_funct3;
  logic        empty;

  int total = 0;
  int bad   = 0;
  bit run   = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  f;
  } ent_t;
  ent_t q[$];

  store_buffer #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_funct3(st_funct3), .st_ready(st_ready), .ld_active(ld_active), .ld_addr(ld_addr),
    .ld_funct3(ld_funct3), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_stall(ld_stall),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] d, input logic [2:0] f);
    int n = nbytes(f);
    longint v = (n == 4) ? longint'(d) : (longint'(d) % (longint'(1) << (8 * n)));
    if (!f[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_fwd(output bit hit, output bit stall, output logic [31:0] data);
    hit = 1'b0; stall = 1'b0; data = 32'h0;
    if (ld_active) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        longint slo = longint'(q[i].a);
        longint shi = slo + nbytes(q[i].f) - 1;
        longint llo = longint'(ld_addr);
        longint lhi = llo + nbytes(ld_funct3) - 1;
        if (slo <= lhi && llo <= shi) begin
          if (q[i].a == ld_addr && nbytes(q[i].f) >= nbytes(ld_funct3)) begin
            hit = 1'b1;
            data = load_value(q[i].d, ld_funct3);
          end else begin
            stall = 1'b1;
          end
          break;
        end
      end
    end
  endtask

  // Reference model state update.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else begin
      bit h, s, wen, rdy;
      logic [31:0] dd;
      model_fwd(h, s, dd);
      wen = (q.size() > 0) && (!ld_active || s);
      rdy = q.size() < 4;
      if (wen) void'(q.pop_front());
      if (st_valid && rdy && st_funct3 inside {3'b000, 3'b001, 3'b010})
        q.push_back('{a: st_addr, d: st_data, f: st_funct3});
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (run) begin
      bit h, s, wen;
      logic [31:0] dd;
      model_fwd(h, s, dd);
      wen = (q.size() > 0) && (!ld_active || s);
      check("empty", {31'b0, empty}, {31'b0, q.size() == 0});
      check("st_ready", {31'b0, st_ready}, {31'b0, q.size() < 4});
      check("fwd_hit", {31'b0, fwd_hit}, {31'b0, h});
      check("ld_stall", {31'b0, ld_stall}, {31'b0, s});
      check("mem_wen", {31'b0, mem_wen}, {31'b0, wen});
      if (h) check("fwd_data", fwd_data, dd);
      if (wen) begin
        check("mem_addr", mem_addr, q[0].a);
        check("mem_wdata", mem_wdata, q[0].d);
        check("mem_funct3", {29'b0, mem_funct3}, {29'b0, q[0].f});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input bit v, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    st_valid = v; st_addr = a; st_data = d; st_funct3 = f;
  endtask

  task automatic set_ld(input bit v, input logic [31:0] a, input logic [2:0] f);
    ld_active = v; ld_addr = a; ld_funct3 = f;
  endtask

  task automatic drain_all;
    int n = 0;
    set_st(1'b0, 32'h0, 32'h0, 3'b010);
    set_ld(1'b0, 32'h0, 3'b010);
    while (!empty && n < 10) begin
      tick();
      n++;
    end
    check("drain_timeout", {31'b0, empty}, 32'h1);
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    run = 1'b1;
    #1;
    // reset state and single store latency
    check("rst_empty", {31'b0, empty}, 32'h1);
    check("rst_ready", {31'b0, st_ready}, 32'h1);
    check("rst_wen", {31'b0, mem_wen}, 32'h0);
    set_st(1'b1, 32'h10000, 32'hDEADBEEF, 3'b010);
    #1 check("t1_no_same_cycle", {31'b0, mem_wen}, 32'h0);
    tick();
    set_st(1'b0, 32'h0, 32'h0, 3'b010);
    #1;
    check("t1_wen", {31'b0, mem_wen}, 32'h1);
    check("t1_addr", mem_addr, 32'h10000);
    check("t1_data", mem_wdata, 32'hDEADBEEF);
    tick();
    check("t1_empty", {31'b0, empty}, 32'h1);

    // fill to full with loads blocking, fifth store dropped
    set_ld(1'b1, 32'h5000, 3'b010);
    for (int i = 0; i < 4; i++) begin
      set_st(1'b1, 32'h400 + 32'(4 * i), 32'(i + 1), 3'b010);
      tick();
    end
    check("t2_full", {31'b0, st_ready}, 32'h0);
    set_st(1'b1, 32'h480, 32'h99, 3'b010);
    tick();
    set_st(1'b0, 32'h0, 32'h0, 3'b010);
    set_ld(1'b0, 32'h0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      #1 check("t2_wen", {31'b0, mem_wen}, 32'h1);
      check("t2_order", mem_wdata, 32'(i + 1));
      tick();
    end
    check("t2_empty", {31'b0, empty}, 32'h1);

    // forwarding with extension
    set_ld(1'b1, 32'h5000, 3'b010);
    set_st(1'b1, 32'h100, 32'h80FF1234, 3'b010);
    tick();
    set_st(1'b0, 32'h0, 32'h0, 3'b010);
    set_ld(1'b1, 32'h100, 3'b000); #1 check("t3_lb", fwd_data, 32'h00000034);
    check("t3_hit", {31'b0, fwd_hit}, 32'h1);
    set_ld(1'b1, 32'h100, 3'b001); #1 check("t3_lh", fwd_data, 32'h00001234);
    set_ld(1'b1, 32'h100, 3'b010); #1 check("t3_lw", fwd_data, 32'h80FF1234);
    set_ld(1'b1, 32'h5000, 3'b010);
    set_st(1'b1, 32'h103, 32'h00000080, 3'b000);
    tick();
    set_st(1'b0, 32'h0, 32'h0, 3'b010);
    set_ld(1'b1, 32'h103, 3'b000); #1 check("t3_lb_sx", fwd_data, 32'hFFFFFF80);
    set_ld(1'b1, 32'h103, 3'b100); #1 check("t3_lbu", fwd_data, 32'h00000080);
    drain_all();

    // partial overlap stalls, drain proceeds
    set_ld(1'b1, 32'h5000, 3'b010);
    set_st(1'b1, 32'h200, 32'h000000AA, 3'b000);
    tick();
    set_st(1'b0, 32'h0, 32'h0, 3'b010);
    set_ld(1'b1, 32'h200, 3'b010);
    #1;
    check("t4_stall", {31'b0, ld_stall}, 32'h1);
    check("t4_nohit", {31'b0, fwd_hit}, 32'h0);
    check("t4_wen", {31'b0, mem_wen}, 32'h1);
    tick();
    check("t4_clear", {31'b0, ld_stall}, 32'h0);
    check("t4_empty", {31'b0, empty}, 32'h1);

    // youngest wins, and no wrap overlap at the top of memory
    set_ld(1'b1, 32'h5000, 3'b010);
    set_st(1'b1, 32'h300, 32'h11111111, 3'b010); tick();
    set_st(1'b1, 32'h300, 32'h00000005, 3'b010); tick();
    set_st(1'b1, 32'hFFFFFFFF, 32'h000000EE, 3'b000); tick();
    set_st(1'b0, 32'h0, 32'h0, 3'b010);
    set_ld(1'b1, 32'h300, 3'b010); #1 check("t5_youngest", fwd_data, 32'h00000005);
    set_ld(1'b1, 32'h0, 3'b010); #1 check("t5_nowrap", {31'b0, ld_stall}, 32'h0);
    drain_all();

    // reset mid-drain
    set_ld(1'b1, 32'h5000, 3'b010);
    for (int i = 0; i < 3; i++) begin
      set_st(1'b1, 32'h600 + 32'(4 * i), 32'hA0 + 32'(i), 3'b010);
      tick();
    end
    set_st(1'b0, 32'h0, 32'h0, 3'b010);
    set_ld(1'b0, 32'h0, 3'b010);
    #1 check("t6_wen_before", {31'b0, mem_wen}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("t6_wen", {31'b0, mem_wen}, 32'h0);
    check("t6_empty", {31'b0, empty}, 32'h1);
    check("t6_ready", {31'b0, st_ready}, 32'h1);
    tick();
    rst = 1'b0;

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      int sel = $urandom_range(0, 3);
      logic [31:0] a;
      if (sel < 2) a = 32'h100 + 32'($urandom_range(0, 11));
      else if (sel == 2) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, 3));
      set_st($urandom_range(0, 9) < 6, a, $urandom, 3'($urandom_range(0, 3)));
      sel = $urandom_range(0, 3);
      if (sel < 2) a = 32'h100 + 32'($urandom_range(0, 11));
      else if (sel == 2) a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else a = 32'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: set_ld($urandom_range(0, 1) == 1, a, 3'b000);
        1: set_ld($urandom_range(0, 1) == 1, a, 3'b001);
        2: set_ld($urandom_range(0, 1) == 1, a, 3'b010);
        3: set_ld($urandom_range(0, 1) == 1, a, 3'b100);
        default: set_ld($urandom_range(0, 1) == 1, a, 3'b101);
      endcase
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        tick();
      end
    end
    drain_all();
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
